uart_tx_arbiter: RTL and testbench

//  Shares one TxUnit between NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and codes for the UART TX arbiter: FSM states, parity/baud codes,
// and the round-robin pointer advance helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] PAR_ODD    = 2'b01;
  localparam logic [1:0] PAR_EVEN   = 2'b10;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [PW-1:0]      grant_idx,
  output logic               valid
);

  int cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && req[cand]) begin
        valid          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TxUnit among NUM_REQ byte sources.
// Optional frame watchdog enabled by defining UART_TX_ARB_WDOG_EN.
//   state   | meaning
//   IDLE    | no owner, arbitrating on req
//   LAUNCH  | winner latched, tx_send held until TxUnit reports active
//   BUSY    | frame in flight, waiting for tx_done
//   RELEASE | one cycle: ack (or tx_error on abort), grant dropped
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [2*NUM_REQ-1:0]   req_parity,
  input  logic [2*NUM_REQ-1:0]   req_baud,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  output logic [1:0]             tx_parity_type,
  output logic [1:0]             tx_baud_rate,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   tx_error
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        winner_q, winner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 tx_send_q, tx_send_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [1:0]           tx_par_q, tx_par_d;
  logic [1:0]           tx_baud_q, tx_baud_d;
  logic                 tx_error_q, tx_error_d;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [PW-1:0]        arb_idx;
  logic                 arb_valid;
  logic                 wdog_hit;
  int                   arb_sel;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

`ifdef UART_TX_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q == IDLE && arb_valid)
      wdog_cnt_d = '0;
    else if (state_q == LAUNCH || state_q == BUSY)
      wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  assign wdog_hit = (state_q == LAUNCH || state_q == BUSY) &&
                    (wdog_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wdog_cnt_q <= '0;
    else          wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    grant_d    = grant_q;
    ack_d      = '0;
    busy_d     = busy_q;
    tx_send_d  = tx_send_q;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    tx_baud_d  = tx_baud_q;
    tx_error_d = 1'b0;
    arb_sel    = int'(arb_idx);

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d   = LAUNCH;
          grant_d   = arb_oh;
          winner_d  = arb_idx;
          busy_d    = 1'b1;
          tx_send_d = 1'b1;
          tx_data_d = req_data[8*arb_sel +: 8];
          tx_par_d  = req_parity[2*arb_sel +: 2];
          tx_baud_d = req_baud[2*arb_sel +: 2];
        end
      end
      LAUNCH, BUSY: begin
        // A frame that actually finished wins over a coincident timeout.
        if (tx_done || wdog_hit) begin
          state_d    = RELEASE;
          tx_send_d  = 1'b0;
          grant_d    = '0;
          ptr_d      = PW'(rr_next(int'(winner_q), NUM_REQ));
          if (tx_done) ack_d = grant_q;
          else         tx_error_d = 1'b1;
        end else if (state_q == LAUNCH && tx_active) begin
          state_d   = BUSY;
          tx_send_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_par_q   <= '0;
      tx_baud_q  <= '0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      tx_par_q   <= tx_par_d;
      tx_baud_q  <= tx_baud_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign grant          = grant_q;
  assign ack            = ack_q;
  assign busy           = busy_q;
  assign tx_send        = tx_send_q;
  assign tx_data        = tx_data_q;
  assign tx_parity_type = tx_par_q;
  assign tx_baud_rate   = tx_baud_q;
  assign tx_error       = tx_error_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural TxUnit stand-in and a frame scoreboard.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int FRAME = 12;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [2*N-1:0]   req_parity, req_baud;
  logic [N-1:0]     grant, ack;
  logic             busy, tx_send, tx_active, tx_done, tx_error;
  logic [7:0]       tx_data;
  logic [1:0]       tx_parity_type, tx_baud_rate;

  always #10 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_parity(req_parity), .req_baud(req_baud), .grant(grant), .ack(ack),
    .busy(busy), .tx_send(tx_send), .tx_data(tx_data),
    .tx_parity_type(tx_parity_type), .tx_baud_rate(tx_baud_rate),
    .tx_active(tx_active), .tx_done(tx_done), .tx_error(tx_error)
  );

  typedef struct {
    int         src;
    logic [7:0] data;
    logic [1:0] par;
    logic [1:0] baud;
  } exp_t;

  typedef struct {
    int         src;
    logic [7:0] data;
    logic [1:0] par;
    logic [1:0] baud;
    int         mode;
  } vec_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         ack_count = 0;
  int         pending[N];
  logic [7:0] next_byte[N];
  int         tx_mode = 0;   // 0 normal frame, 1 done without active, 2 never finishes
  logic       send_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      step();
      n++;
    end
    check(name, ack_count, target);
  endtask

  task automatic load_src(input int s, input logic [7:0] d, input logic [1:0] p,
                          input logic [1:0] b, input int cnt);
    exp_t e;
    req_data[8*s +: 8]   = d;
    req_parity[2*s +: 2] = p;
    req_baud[2*s +: 2]   = b;
    pending[s]           = cnt;
    e.src = s; e.data = d; e.par = p; e.baud = b;
    sb.push_back(e);
  endtask

  // TxUnit stand-in
  int  m_cnt;
  logic m_run;
  initial begin
    tx_active = 1'b0; tx_done = 1'b0; m_cnt = 0; m_run = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n || !busy) begin
        m_run = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
      end else if (!m_run) begin
        tx_done = 1'b0;
        if (tx_send) begin m_run = 1'b1; m_cnt = 0; end
      end else begin
        m_cnt++;
        case (tx_mode)
          0: begin
            if (m_cnt == 2) tx_active = 1'b1;
            if (m_cnt == FRAME) begin tx_active = 1'b0; tx_done = 1'b1; m_run = 1'b0; end
          end
          1: if (m_cnt == 1) begin tx_done = 1'b1; m_run = 1'b0; end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard monitor; requesters drop req once their last byte is acked
  initial begin
    exp_t e;
    int   s;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (tx_send && !send_prev) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL launch_unexpected: grant=%b with no frame expected", grant);
          end else begin
            check("launch_grant", 32'(grant), 32'(1) << sb[0].src);
          end
        end
        if (ack != '0) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_unexpected: ack=%b with no frame expected", ack);
          end else begin
            e = sb.pop_front();
            s = e.src;
            check("ack_onehot", 32'(ack), 32'(1) << s);
            check("ack_data", 32'(tx_data), 32'(e.data));
            check("ack_parity", 32'(tx_parity_type), 32'(e.par));
            check("ack_baud", 32'(tx_baud_rate), 32'(e.baud));
            check("ack_grant_low", 32'(grant), 0);
            ack_count++;
            pending[s]--;
            if (pending[s] <= 0) req[s] = 1'b0;
            else req_data[8*s +: 8] = next_byte[s];
          end
        end
      end
      send_prev = tx_send;
    end
  end

  vec_t vecs[5];
  int   base;
  int   n;

  initial begin
    vecs[0] = '{1, 8'h5A, PAR_EVEN, BAUD_19200, 0};
    vecs[1] = '{3, 8'hC3, PAR_ODD,  BAUD_9600,  0};
    vecs[2] = '{0, 8'h00, 2'b00,    2'b00,      1};
    vecs[3] = '{3, 8'hFF, 2'b11,    2'b01,      1};
    vecs[4] = '{2, 8'h81, PAR_EVEN, BAUD_9600,  0};
    req = '0; req_data = '0; req_parity = '0; req_baud = '0;
    for (int i = 0; i < N; i++) begin pending[i] = 0; next_byte[i] = 8'h00; end
    reset_n = 1'b0;

    // reset values
    #100;
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_error", 32'(tx_error), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) step();

    // round robin with all four requesting; source 0 has a second byte
    load_src(0, 8'h11, PAR_ODD, BAUD_9600, 2);
    load_src(1, 8'h22, PAR_EVEN, BAUD_19200, 1);
    load_src(2, 8'h33, PAR_ODD, BAUD_19200, 1);
    load_src(3, 8'h44, PAR_EVEN, BAUD_9600, 1);
    next_byte[0] = 8'h15;
    begin exp_t e; e.src = 0; e.data = 8'h15; e.par = PAR_ODD; e.baud = BAUD_9600; sb.push_back(e); end
    base = ack_count;
    req = 4'hF;
    wait_acks(base + 5, 5 * 40, "rr_acks");
    repeat (3) step();
    check("rr_idle_busy", 32'(busy), 0);

    // single request, one cycle from req to tx_send
    load_src(0, 8'hAA, PAR_ODD, BAUD_9600, 1);
    base = ack_count;
    req[0] = 1'b1;
    step();
    check("single_send", 32'(tx_send), 1);
    check("single_grant", 32'(grant), 32'h1);
    check("single_busy", 32'(busy), 1);
    wait_acks(base + 1, 40, "single_ack");
    step();

    // source 1 byte changes mid-frame
    load_src(1, 8'h3C, PAR_EVEN, BAUD_9600, 1);
    base = ack_count;
    req[1] = 1'b1;
    n = 0;
    while (!grant[1] && n < 20) begin step(); n++; end
    check("mid_grant", 32'(grant[1]), 1);
    req_data[15:8] = 8'h55;
    repeat (4) step();
    check("mid_hold", 32'(tx_data), 32'h3C);
    wait_acks(base + 1, 40, "mid_ack");
    step();

    // table of single-source frames, including done-without-active
    for (int i = 0; i < 5; i++) begin
      tx_mode = vecs[i].mode;
      load_src(vecs[i].src, vecs[i].data, vecs[i].par, vecs[i].baud, 1);
      base = ack_count;
      req[vecs[i].src] = 1'b1;
      wait_acks(base + 1, 40, $sformatf("vec%0d_ack", i));
      step();
    end
    tx_mode = 0;

    // reset mid-frame; pointer (now 3) must return to 0
    load_src(3, 8'h77, PAR_ODD, BAUD_9600, 1);
    req[3] = 1'b1;
    repeat (7) step();
    check("midrst_busy_pre", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_send", 32'(tx_send), 0);
    check("midrst_data", 32'(tx_data), 0);
    sb.delete();
    req = '0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    load_src(1, 8'h19, PAR_EVEN, BAUD_19200, 1);
    load_src(3, 8'h93, PAR_ODD, BAUD_9600, 1);
    base = ack_count;
    req = 4'b1010;
    wait_acks(base + 2, 80, "postrst_acks");
    step();

`ifdef UART_TX_ARB_WDOG_EN
    // watchdog abort on a TxUnit that never finishes
    tx_mode = 2;
    load_src(0, 8'hE1, PAR_ODD, BAUD_9600, 1);
    load_src(1, 8'h1E, PAR_EVEN, BAUD_9600, 1);
    base = ack_count;
    req = 4'b0011;
    n = 0;
    while (!tx_send && n < 10) begin step(); n++; end
    check("wdog_launch", 32'(tx_send), 1);
    n = 0;
    while (!tx_error && n < 200) begin step(); n++; end
    check("wdog_cycles", n, 100);
    check("wdog_no_ack", 32'(ack), 0);
    check("wdog_grant", 32'(grant), 0);
    check("wdog_send", 32'(tx_send), 0);
    void'(sb.pop_front());
    req[0] = 1'b0;
    pending[0] = 0;
    tx_mode = 0;
    step();
    check("wdog_idle", 32'(busy), 0);
    check("wdog_err_pulse", 32'(tx_error), 0);
    wait_acks(base + 1, 40, "wdog_next_ack");
`else
    // without the watchdog a hung TxUnit holds the controller indefinitely
    tx_mode = 2;
    load_src(0, 8'hE1, PAR_ODD, BAUD_9600, 1);
    req[0] = 1'b1;
    repeat (150) step();
    check("hang_busy", 32'(busy), 1);
    check("hang_send", 32'(tx_send), 1);
    check("hang_error", 32'(tx_error), 0);
    reset_n = 1'b0;
    sb.delete();
    req = '0;
    pending[0] = 0;
    tx_mode = 0;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("hang_rst_busy", 32'(busy), 0);
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
